// File: rtl/dmem_request_ctrl.sv
// Data/instruction memory request controller: issues registered data requests and holds them until dhit.
// Optional per-type request and stall counters: define REQ_STATS_EN.
module dmem_request_ctrl #(
    parameter int WORD_W   = 32,
    parameter int WAIT_W   = 8,
    parameter int MAX_WAIT = 255
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              ihit,
    input  logic              dhit,
    input  logic              memRead,
    input  logic              memWr,
    input  logic              halt,
    input  logic [WORD_W-1:0] daddr_in,
    input  logic [WORD_W-1:0] dstore_in,
    output logic              imemREN,
    output logic              dmemREN,
    output logic              dmemWEN,
    output logic [WORD_W-1:0] dmemaddr,
    output logic [WORD_W-1:0] dmemstore,
    output logic              pc_en,
    output logic              busy,
    output logic              timeout_err,
    output logic              halted
`ifdef REQ_STATS_EN
    ,
    output logic [31:0]       rd_count,
    output logic [31:0]       wr_count,
    output logic [31:0]       stall_cycles
`endif
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        HALTED = 2'd2
    } state_t;

    localparam logic [WAIT_W-1:0] MAXW = WAIT_W'(MAX_WAIT);

    state_t            state;
    logic [WAIT_W-1:0] wait_cnt;
    logic              memop;
    logic              issue;
    logic              stall;

    assign memop  = memRead | memWr;
    assign issue  = (state == IDLE) & ihit & memop;
    assign stall  = (state == REQ) & ~dhit;
    assign busy   = (state == REQ);
    assign halted = (state == HALTED);
    assign pc_en  = ((state == IDLE) & ihit & ~memop & ~halt)
                  | ((state == REQ) & dhit);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state       <= IDLE;
            imemREN     <= 1'b1;
            dmemREN     <= 1'b0;
            dmemWEN     <= 1'b0;
            dmemaddr    <= '0;
            dmemstore   <= '0;
            wait_cnt    <= '0;
            timeout_err <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (ihit && memop) begin
                        state     <= REQ;
                        dmemaddr  <= daddr_in;
                        dmemstore <= dstore_in;
                        dmemWEN   <= memWr;
                        dmemREN   <= memRead & ~memWr;
                    end else if (ihit && halt) begin
                        state   <= HALTED;
                        imemREN <= 1'b0;
                    end
                end
                REQ: begin
                    if (dhit) begin
                        dmemREN  <= 1'b0;
                        dmemWEN  <= 1'b0;
                        wait_cnt <= '0;
                        if (halt) begin
                            state   <= HALTED;
                            imemREN <= 1'b0;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        // counter saturates; timeout flags on the cycle it hits MAX_WAIT
                        if (wait_cnt != MAXW)
                            wait_cnt <= wait_cnt + 1'b1;
                        if (wait_cnt == MAXW - 1'b1 || wait_cnt == MAXW)
                            timeout_err <= 1'b1;
                    end
                end
                HALTED: begin
                    imemREN <= 1'b0;
                    dmemREN <= 1'b0;
                    dmemWEN <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef REQ_STATS_EN
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            rd_count     <= '0;
            wr_count     <= '0;
            stall_cycles <= '0;
        end else begin
            if (issue && memWr)
                wr_count <= wr_count + 32'd1;
            if (issue && !memWr)
                rd_count <= rd_count + 32'd1;
            if (stall)
                stall_cycles <= stall_cycles + 32'd1;
        end
    end
`else
    logic unused_stats;
    assign unused_stats = issue ^ stall;
`endif

endmodule

// File: doc/dmem_request_ctrl.md
Name: dmem_request_ctrl

Overview:
Parametrised data/instruction memory request controller for the single-cycle/multicycle CPU datapath, sitting between control/datapath and the memory interface (caches or memory controller).
- Keeps imemREN asserted and issues registered dmemREN/dmemWEN with latched address and store data.
- Holds a data request until dhit, produces the PC-advance enable, and handles halt.
- Counts wait cycles and flags a timeout.

Parameters:
WORD_W, 32, width of address and store data buses
WAIT_W, 8, width of the wait-cycle counter
MAX_WAIT, 255, wait-cycle count at which timeout_err sets (must be < 2**WAIT_W)

Ports:
CLK  input  1  clock, rising edge
nRST  input  1  reset, asynchronous, active-low
ihit  input  1  instruction fetch completed this cycle
dhit  input  1  data access completed this cycle
memRead  input  1  current instruction is a load
memWr  input  1  current instruction is a store
halt  input  1  current instruction is halt
daddr_in  input  WORD_W  effective address from ALU
dstore_in  input  WORD_W  store data from register file
imemREN  output  1  instruction read enable
dmemREN  output  1  data read enable (registered)
dmemWEN  output  1  data write enable (registered)
dmemaddr  output  WORD_W  latched data address
dmemstore  output  WORD_W  latched store data
pc_en  output  1  PC may advance this cycle (combinational)
busy  output  1  data request outstanding (state==REQ)
timeout_err  output  1  sticky: a request waited MAX_WAIT cycles
halted  output  1  controller in HALTED state

Behaviour:
Reset (async, nRST low):
- State IDLE; imemREN=1; dmemREN=0, dmemWEN=0; dmemaddr=0, dmemstore=0.
- Wait counter=0; timeout_err=0; halted=0.

State IDLE:
- On ihit & (memRead|memWr): latch daddr_in→dmemaddr and dstore_in→dmemstore, then go to REQ.
- In that transition, dmemWEN<=memWr and dmemREN<=memRead & ~memWr; write wins when both are set, never both.
- On ihit & halt & ~(memRead|memWr): go to HALTED.
- Otherwise stay in IDLE. Data enables stay 0.

State REQ:
- Enables, address and data are held stable until dhit.
- On dhit: next edge clears both enables, clears the wait counter, and goes to IDLE. If halt is also high, it goes to HALTED instead.
- Each REQ cycle without dhit increments the wait counter, saturating at MAX_WAIT.
- When the counter reaches MAX_WAIT, timeout_err<=1 (sticky until reset). The request stays outstanding; no abort.

State HALTED:
- imemREN<=0, halted=1; all data enables 0.
- Absorbing; left only via reset.

imemREN:
- 1 in IDLE and REQ; 0 in HALTED from the cycle after entry.

pc_en (combinational):
- (IDLE & ihit & ~(memRead|memWr) & ~halt) | (REQ & dhit). Never 1 in HALTED.

busy:
- 1 exactly in REQ.

Boundary conditions:
- dhit in IDLE is ignored, with no state change.
- ihit in REQ is ignored; no new latch.
- A request issued in the cycle right after dhit is allowed: IDLE→REQ back-to-back, giving one enable-low cycle between requests.
- Reset mid-REQ drops enables immediately (async).

Optional Feature:
Macro REQ_STATS_EN.
- Defined: adds outputs rd_count [31:0], wr_count [31:0] and stall_cycles [31:0].
  - rd_count increments on each IDLE→REQ read issue; wr_count on each write issue.
  - stall_cycles increments on every REQ cycle without dhit.
  - All three reset to 0 and wrap modulo 2**32.
- Not defined: these ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset → imemREN=1, dmemREN=0, dmemWEN=0, busy=0, timeout_err=0, halted=0; assert nRST low mid-REQ → enables drop in the same cycle.
- ihit, memRead=1, daddr_in=0x0000_0040 → next cycle dmemREN=1, dmemaddr=0x40, busy=1; dhit after 3 cycles → pc_en=1 that cycle, dmemREN=0 next cycle.
- ihit, memRead=1 and memWr=1, dstore_in=0xDEAD_BEEF → dmemWEN=1, dmemREN=0, dmemstore=0xDEADBEEF.
- MAX_WAIT=4, store with no dhit → timeout_err=1 after 4 REQ cycles and stays 1 after a later dhit; dmemWEN held until dhit.
- ihit, halt=1, no mem op → halted=1, imemREN=0 next cycle; later ihit/memRead pulses → no enables asserted.
- With REQ_STATS_EN: 2 loads + 1 store, each waiting 2 cycles → rd_count=2, wr_count=1, stall_cycles=6.
